load_store_unit: RTL and testbench

CPU-side Wishbone master that converts core load/store requests (byte, halfword, word; signed or unsigned) into word-aligned bus transactions with byte selects. It sits between the execute stage and the data bus, directly upstream of the data memory slave. It drives the lane steering and sign extension, rejects misaligned accesses locally, and bounds every transaction with a timeout.

---
 rtl/lsu_pkg.sv | 22 ++
 rtl/load_store_unit_if.sv | 15 +
 rtl/lsu_lane_align.sv | 57 +++++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, FSM states and the
// timeout counter width helper.
package lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } lsu_state_t;

  // Timeout counter only has to reach cycles-1; keep at least one bit.
  function automatic int tmo_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Wishbone classic data bus between the load/store unit and a memory slave.
interface wb_bus;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [3:0]  sel;
  logic        we;
  logic        stb;
  logic        cyc;
  logic        ack;
  logic        err;

  modport master (output addr, wdata, sel, we, stb, cyc, input ack, err, rdata);
  modport slave  (input addr, wdata, sel, we, stb, cyc, output ack, err, rdata);
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for stores, misalignment detect, and
// load extraction with sign/zero extension.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata_raw,
  output logic [3:0]  sel,
  output logic [31:0] wdata_lane,
  output logic        misaligned,
  input  logic [1:0]  ld_size,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] bus_rdata,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;

  always_comb begin
    sel        = 4'b0000;
    wdata_lane = wdata_raw;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: begin
        sel        = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata_raw[7:0]}};
      end
      SIZE_HALF: begin
        sel        = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata_raw[15:0]}};
        misaligned = addr_lo[0];
      end
      SIZE_WORD: begin
        sel        = 4'b1111;
        misaligned = |addr_lo;
      end
      default: misaligned = 1'b1;
    endcase
  end

  // Bring the addressed lane down to bit 0, then extend from its top bit.
  assign shifted = bus_rdata >> {ld_addr_lo, 3'b000};

  always_comb begin
    ld_data = bus_rdata;
    case (ld_size)
      SIZE_BYTE: ld_data = ld_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SIZE_HALF: ld_data = ld_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default:   ld_data = bus_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Wishbone master turning core byte/half/word loads and stores into aligned
// bus cycles, with local misalignment rejection and a strobe timeout.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TimeoutCycles = 16
) (
  input  logic         clk_in,
  input  logic         reset_in,
  input  logic         req_in,
  input  logic         we_in,
  input  logic [1:0]   size_in,
  input  logic         unsigned_in,
  input  logic [31:0]  addr_in,
  input  logic [31:0]  wdata_in,
  output logic         busy_out,
  output logic         done_out,
  output logic         err_out,
  output logic [31:0]  rdata_out,
  wb_bus.master        bus_master
);

  localparam int TW = tmo_width(TimeoutCycles);

  lsu_state_t    state, state_nxt;
  logic [1:0]    size_q, alo_q;
  logic          we_q, uns_q;
  logic [TW-1:0] tmo_cnt;
  logic          fin_err, fin_load;
  logic [3:0]    sel_c;
  logic [31:0]   wdata_c, ld_c;
  logic          mis_c;

  lsu_lane_align u_align (
    .size        (size_in),
    .addr_lo     (addr_in[1:0]),
    .wdata_raw   (wdata_in),
    .sel         (sel_c),
    .wdata_lane  (wdata_c),
    .misaligned  (mis_c),
    .ld_size     (size_q),
    .ld_addr_lo  (alo_q),
    .ld_unsigned (uns_q),
    .bus_rdata   (bus_master.rdata),
    .ld_data     (ld_c)
  );

  always_comb begin
    state_nxt = state;
    fin_err   = 1'b0;
    unique case (state)
      IDLE: if (req_in) begin
        state_nxt = mis_c ? DONE : BUS;
        fin_err   = mis_c;
      end
      BUS: begin
        // err outranks ack; timeout only when the slave stays silent
        if (bus_master.err) begin
          state_nxt = DONE;
          fin_err   = 1'b1;
        end else if (bus_master.ack) begin
          state_nxt = DONE;
        end else if (tmo_cnt == TW'(TimeoutCycles - 1)) begin
          state_nxt = DONE;
          fin_err   = 1'b1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A misaligned request finishes straight from IDLE, before we_q is loaded.
  assign fin_load = (state == IDLE) ? ~we_in : ~we_q;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state            <= IDLE;
      size_q           <= 2'b00;
      alo_q            <= 2'b00;
      we_q             <= 1'b0;
      uns_q            <= 1'b0;
      tmo_cnt          <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      err_out          <= 1'b0;
      rdata_out        <= 32'h0;
      bus_master.addr  <= 32'h0;
      bus_master.wdata <= 32'h0;
      bus_master.sel   <= 4'h0;
      bus_master.we    <= 1'b0;
      bus_master.stb   <= 1'b0;
      bus_master.cyc   <= 1'b0;
    end else begin
      state          <= state_nxt;
      busy_out       <= (state_nxt != IDLE);
      done_out       <= (state_nxt == DONE);
      err_out        <= (state_nxt == DONE) && fin_err;
      bus_master.stb <= (state_nxt == BUS);
      bus_master.cyc <= (state_nxt == BUS);

      if (state == IDLE && req_in) begin
        size_q           <= size_in;
        alo_q            <= addr_in[1:0];
        we_q             <= we_in;
        uns_q            <= unsigned_in;
        tmo_cnt          <= '0;
        bus_master.addr  <= {addr_in[31:2], 2'b00};
        bus_master.wdata <= wdata_c;
        bus_master.sel   <= sel_c;
        bus_master.we    <= we_in;
      end else if (state == BUS && state_nxt == BUS) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (state_nxt == DONE && fin_load)
        rdata_out <= fin_err ? 32'h0 : ld_c;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, randomized ops against a
// byte-level memory model, and a reset-during-transaction sequence.
module tb_load_store_unit;

  localparam int TMO = 4;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        req_in, we_in, unsigned_in;
  logic [1:0]  size_in;
  logic [31:0] addr_in, wdata_in;
  logic        busy_out, done_out, err_out;
  logic [31:0] rdata_out;

  wb_bus bus ();

  load_store_unit #(.TimeoutCycles(TMO)) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .req_in      (req_in),
    .we_in       (we_in),
    .size_in     (size_in),
    .unsigned_in (unsigned_in),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .busy_out    (busy_out),
    .done_out    (done_out),
    .err_out     (err_out),
    .rdata_out   (rdata_out),
    .bus_master  (bus)
  );

  always #5 clk_in = ~clk_in;

  // Memory slave: registered response after wait_st extra cycles.
  // slv_mode 0 = ack, 1 = bus error, 2 = never respond.
  int          slv_mode = 0;
  int          wait_st  = 0;
  int          wcnt;
  logic [31:0] mem [16];

  always @(posedge clk_in) begin
    bus.ack <= 1'b0;
    bus.err <= 1'b0;
    if (reset_in) begin
      wcnt      <= 0;
      bus.rdata <= 32'h0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
    end else if (bus.cyc && bus.stb && !bus.ack && !bus.err) begin
      if (wcnt == wait_st) begin
        if (slv_mode == 0) begin
          bus.ack   <= 1'b1;
          bus.rdata <= mem[bus.addr[5:2]];
          if (bus.we)
            for (int l = 0; l < 4; l++)
              if (bus.sel[l]) mem[bus.addr[5:2]][8*l +: 8] <= bus.wdata[8*l +: 8];
        end else if (slv_mode == 1) begin
          bus.err <= 1'b1;
        end
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      wcnt <= 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference memory as bytes for 0x3000..0x303F.
  logic [7:0] ref_mem [64];

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic uns);
    int n = 1 << sz;
    int off = int'(a - 32'h3000);
    logic [63:0] v = 64'h0;
    for (int b = 0; b < n; b++) v |= 64'(ref_mem[off + b]) << (8 * b);
    if (!uns && n < 4 && v[8*n-1]) v |= ~64'h0 << (8 * n);
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int off = int'(a - 32'h3000);
    for (int b = 0; b < (1 << sz); b++) ref_mem[off + b] = wd[8*b +: 8];
  endtask

  // Issue one request and watch it until done_out or a 20-cycle bound.
  task automatic run_op(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int done_c, output int stb_c, output logic e,
                        output logic [31:0] rd, output logic [31:0] b_addr,
                        output logic [3:0] b_sel, output logic [31:0] b_wd,
                        output logic b_we, output logic busy_ok, output logic stable);
    @(negedge clk_in);
    req_in = 1'b1; we_in = we; size_in = sz; unsigned_in = uns; addr_in = a; wdata_in = wd;
    @(posedge clk_in);
    #1 req_in = 1'b0;
    done_c = -1; stb_c = 0; e = 1'b0; rd = 32'h0; busy_ok = 1'b1; stable = 1'b1;
    b_addr = 32'h0; b_sel = 4'h0; b_wd = 32'h0; b_we = 1'b0;
    for (int c = 1; c <= 20 && done_c < 0; c++) begin
      @(negedge clk_in);
      if (!busy_out) busy_ok = 1'b0;
      if (bus.stb) begin
        if (stb_c == 0) begin
          b_addr = bus.addr; b_sel = bus.sel; b_wd = bus.wdata; b_we = bus.we;
        end else if (bus.addr !== b_addr || bus.sel !== b_sel ||
                     bus.wdata !== b_wd || bus.we !== b_we || !bus.cyc) begin
          stable = 1'b0;
        end
        stb_c++;
      end
      if (done_out) begin
        done_c = c; e = err_out; rd = rdata_out;
      end
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          mode;
    int          wt;
    int          e_done;
    int          e_stb;
    logic        e_err;
    logic [31:0] e_rd;
    logic [3:0]  e_sel;
    logic [31:0] e_baddr;
    logic [31:0] e_bwd;
  } vec_t;

  vec_t vt [15];

  int          dc, sc;
  logic        e, bwe, bok, stab;
  logic [31:0] rd, ba, bwd, hold;
  logic [3:0]  bs;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h0;
    req_in = 0; we_in = 0; size_in = 0; unsigned_in = 0; addr_in = 0; wdata_in = 0;
    reset_in = 1'b1;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("reset stb", {31'h0, bus.stb}, 32'h0);
    check("reset cyc", {31'h0, bus.cyc}, 32'h0);
    check("reset we", {31'h0, bus.we}, 32'h0);
    check("reset sel", {28'h0, bus.sel}, 32'h0);
    check("reset addr", bus.addr, 32'h0);
    check("reset wdata", bus.wdata, 32'h0);
    check("reset busy/done/err", {29'h0, busy_out, done_out, err_out}, 32'h0);
    check("reset rdata", rdata_out, 32'h0);
    reset_in = 1'b0;

    //        we   sz    uns   addr        wdata        md wt dn st err   rd            sel    baddr       bwd
    vt[0]  = '{1'b1, 2'd2, 1'b0, 32'h3004, 32'hDEADBEEF, 0, 0, 3, 2, 1'b0, 32'h00000000, 4'hF, 32'h3004, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h3007, 32'h0,        0, 0, 3, 2, 1'b0, 32'hFFFFFFDE, 4'h8, 32'h3004, 32'h0};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h3007, 32'h0,        0, 0, 3, 2, 1'b0, 32'h000000DE, 4'h8, 32'h3004, 32'h0};
    vt[3]  = '{1'b0, 2'd1, 1'b0, 32'h3004, 32'h0,        0, 0, 3, 2, 1'b0, 32'hFFFFBEEF, 4'h3, 32'h3004, 32'h0};
    vt[4]  = '{1'b1, 2'd1, 1'b0, 32'h3002, 32'h00001234, 0, 0, 3, 2, 1'b0, 32'hFFFFBEEF, 4'hC, 32'h3000, 32'h12341234};
    vt[5]  = '{1'b0, 2'd2, 1'b0, 32'h3000, 32'h0,        0, 0, 3, 2, 1'b0, 32'h12340000, 4'hF, 32'h3000, 32'h0};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 32'h3002, 32'h0,        0, 0, 1, 0, 1'b1, 32'h00000000, 4'h0, 32'h0,    32'h0};
    vt[7]  = '{1'b1, 2'd1, 1'b0, 32'h3001, 32'h5555,     0, 0, 1, 0, 1'b1, 32'h00000000, 4'h0, 32'h0,    32'h0};
    vt[8]  = '{1'b0, 2'd0, 1'b1, 32'h3006, 32'h0,        0, 1, 4, 3, 1'b0, 32'h000000AD, 4'h4, 32'h3004, 32'h0};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'h3004, 32'h0,        2, 0, TMO+1, TMO, 1'b1, 32'h0, 4'hF, 32'h3004, 32'h0};
    vt[10] = '{1'b0, 2'd1, 1'b1, 32'h3006, 32'h0,        0, 0, 3, 2, 1'b0, 32'h0000DEAD, 4'hC, 32'h3004, 32'h0};
    vt[11] = '{1'b0, 2'd2, 1'b0, 32'h3004, 32'h0,        1, 0, 3, 2, 1'b1, 32'h00000000, 4'hF, 32'h3004, 32'h0};
    vt[12] = '{1'b1, 2'd0, 1'b0, 32'h3001, 32'h77,       1, 0, 3, 2, 1'b1, 32'h00000000, 4'h2, 32'h3000, 32'h77777777};
    vt[13] = '{1'b0, 2'd3, 1'b0, 32'h3000, 32'h0,        0, 0, 1, 0, 1'b1, 32'h00000000, 4'h0, 32'h0,    32'h0};
    vt[14] = '{1'b1, 2'd0, 1'b0, 32'h3003, 32'hA5,       0, 2, 5, 4, 1'b0, 32'h00000000, 4'h8, 32'h3000, 32'hA5A5A5A5};

    foreach (vt[i]) begin
      slv_mode = vt[i].mode; wait_st = vt[i].wt;
      run_op(vt[i].we, vt[i].size, vt[i].uns, vt[i].addr, vt[i].wdata,
             dc, sc, e, rd, ba, bs, bwd, bwe, bok, stab);
      check($sformatf("vec%0d done cycle", i), dc, vt[i].e_done);
      check($sformatf("vec%0d stb cycles", i), sc, vt[i].e_stb);
      check($sformatf("vec%0d err", i), {31'h0, e}, {31'h0, vt[i].e_err});
      check($sformatf("vec%0d rdata", i), rd, vt[i].e_rd);
      check($sformatf("vec%0d busy", i), {31'h0, bok}, 32'h1);
      if (vt[i].e_stb > 0) begin
        check($sformatf("vec%0d bus addr", i), ba, vt[i].e_baddr);
        check($sformatf("vec%0d bus sel", i), {28'h0, bs}, {28'h0, vt[i].e_sel});
        check($sformatf("vec%0d bus we", i), {31'h0, bwe}, {31'h0, vt[i].we});
        check($sformatf("vec%0d bus stable", i), {31'h0, stab}, 32'h1);
        if (vt[i].we) check($sformatf("vec%0d bus wdata", i), bwd, vt[i].e_bwd);
      end
      if (vt[i].we && !vt[i].e_err) ref_store(vt[i].addr, vt[i].size, vt[i].wdata);
      hold = vt[i].e_rd;
    end

    // Read-back after the directed stores, through the reference model.
    slv_mode = 0; wait_st = 0;
    run_op(1'b0, 2'd2, 1'b0, 32'h3000, 32'h0, dc, sc, e, rd, ba, bs, bwd, bwe, bok, stab);
    check("readback word 0x3000", rd, 32'hA5340000);
    check("readback model", rd, ref_load(32'h3000, 2'd2, 1'b0));
    hold = rd;

    for (int k = 0; k < 200; k++) begin
      logic        rwe, runs, alig;
      logic [1:0]  rsz;
      logic [31:0] ra, rwd, exp_rd, lanes;
      logic [3:0]  esel;
      int          off, n, ed, es;
      rwe  = 1'($urandom_range(0, 1));
      rsz  = 2'($urandom_range(0, 3));
      runs = 1'($urandom_range(0, 1));
      ra   = 32'h3000 + 32'($urandom_range(0, 60));
      rwd  = $urandom;
      wait_st  = $urandom_range(0, 2);
      slv_mode = ($urandom_range(0, 9) == 0) ? 1 : (($urandom_range(0, 15) == 0) ? 2 : 0);
      off  = int'(ra % 4);
      n    = 1 << rsz;
      alig = (rsz == 2'd0) || (rsz == 2'd1 && off % 2 == 0) || (rsz == 2'd2 && off == 0);
      esel = 4'(((1 << n) - 1) << off);
      lanes = 32'h0;
      for (int l = 0; l < 4; l++)
        if (esel[l]) lanes[8*l +: 8] = rwd[8*(l - off) +: 8];
      if (!alig)              begin ed = 1;           es = 0;       end
      else if (slv_mode == 2) begin ed = TMO + 1;     es = TMO;     end
      else                    begin ed = 3 + wait_st; es = 2 + wait_st; end
      if (rwe) exp_rd = hold;
      else if (alig && slv_mode == 0) exp_rd = ref_load(ra, rsz, runs);
      else exp_rd = 32'h0;

      run_op(rwe, rsz, runs, ra, rwd, dc, sc, e, rd, ba, bs, bwd, bwe, bok, stab);
      check($sformatf("rnd%0d done cycle", k), dc, ed);
      check($sformatf("rnd%0d stb cycles", k), sc, es);
      check($sformatf("rnd%0d err", k), {31'h0, e}, {31'h0, !(alig && slv_mode == 0)});
      check($sformatf("rnd%0d rdata", k), rd, exp_rd);
      if (alig) begin
        check($sformatf("rnd%0d bus addr", k), ba, ra & ~32'h3);
        check($sformatf("rnd%0d bus sel", k), {28'h0, bs}, {28'h0, esel});
        check($sformatf("rnd%0d bus we", k), {31'h0, bwe}, {31'h0, rwe});
        check($sformatf("rnd%0d bus stable", k), {31'h0, stab}, 32'h1);
        if (rwe) begin
          logic [31:0] m;
          m = 32'h0;
          for (int l = 0; l < 4; l++) if (esel[l]) m[8*l +: 8] = 8'hFF;
          check($sformatf("rnd%0d bus wdata", k), bwd & m, lanes);
        end
      end
      if (rwe && alig && slv_mode == 0) ref_store(ra, rsz, rwd);
      hold = exp_rd;
    end

    // Reset during cycle 1 of a slow load: bus drops, no completion appears.
    slv_mode = 0; wait_st = 2;
    @(negedge clk_in);
    req_in = 1'b1; we_in = 1'b0; size_in = 2'd2; unsigned_in = 1'b0; addr_in = 32'h3000;
    @(posedge clk_in);
    #1 req_in = 1'b0; reset_in = 1'b1;
    @(negedge clk_in);
    check("midreset stb in cycle 1", {31'h0, bus.stb}, 32'h1);
    @(posedge clk_in);
    #1 reset_in = 1'b0;
    @(negedge clk_in);
    check("midreset stb", {31'h0, bus.stb}, 32'h0);
    check("midreset cyc", {31'h0, bus.cyc}, 32'h0);
    check("midreset busy", {31'h0, busy_out}, 32'h0);
    begin
      int seen = 0;
      repeat (10) begin
        @(negedge clk_in);
        if (done_out) seen++;
      end
      check("midreset no done", seen, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
